// File: rtl/cnl_job_seq_pkg.sv
// Shared types and default sizing for the quad job sequencer.
// No logic; constants and the FSM state encoding only.
// Not applicable (no datapath).
package cnl_job_seq_pkg;

    localparam int unsigned C_PARAM_W_DEF        = 128;
    localparam int unsigned C_RESULT_W_DEF       = 16;
    localparam int unsigned C_CNT_W_DEF          = 32;
    localparam int unsigned C_TIMEOUT_CYCLES_DEF = 1000000;

    // Job-protocol phases as seen from the host side of the quad.
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START      = 3'd1,
        WAIT_FETCH = 3'd2,
        FETCHING   = 3'd3,
        RUN        = 3'd4,
        ERROR      = 3'd5
    } state_t;

endpackage

// File: rtl/cnl_watchdog_timer.sv
// Reloadable down-counter; expired rises after C_TIMEOUT_CYCLES enabled cycles without reload.
// Latency: expired is decoded from the counter register, valid the cycle the count reaches zero.
// No backpressure; disabling the timer holds it at its reload value.
module cnl_watchdog_timer
    import cnl_job_seq_pkg::*;
#(
    parameter int unsigned C_TIMEOUT_CYCLES = C_TIMEOUT_CYCLES_DEF
) (
    input  logic clk_if,
    input  logic rst_n,
    input  logic enable,
    input  logic reload,
    output logic expired
);

    // Counter holds "cycles remaining minus one", so a reload value of N-1 expires on cycle N.
    localparam int unsigned CW = (C_TIMEOUT_CYCLES > 1) ? $clog2(C_TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] RELOAD_VAL = CW'(C_TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: park at reload value when idle or kicked, otherwise count down to zero.
    always_comb begin
        cnt_d = cnt_q;
        if (!enable || reload) begin
            cnt_d = RELOAD_VAL;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk_if or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= RELOAD_VAL;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = enable && (cnt_q == '0);

endmodule

// File: rtl/cnl_job_sequencer.sv
// Host-side initiator for one quad: descriptor -> start/fetch/complete handshakes, results forwarded downstream.
// Latency: job_start one cycle after descriptor accept; fetch/complete acks and result passthrough are same-cycle.
// Backpressure: desc_ready low while busy; result_accept mirrors res_ready during FETCHING/RUN, else 0.
module cnl_job_sequencer
    import cnl_job_seq_pkg::*;
#(
    parameter int unsigned C_PARAM_W        = C_PARAM_W_DEF,
    parameter int unsigned C_RESULT_W       = C_RESULT_W_DEF,
    parameter int unsigned C_CNT_W          = C_CNT_W_DEF,
    parameter int unsigned C_TIMEOUT_CYCLES = C_TIMEOUT_CYCLES_DEF
) (
    input  logic                  clk_if,
    input  logic                  rst_n,
    input  logic                  desc_valid,
    output logic                  desc_ready,
    input  logic [C_PARAM_W-1:0]  desc_params,
    input  logic [C_CNT_W-1:0]    desc_num_results,
    output logic                  job_start,
    input  logic                  job_accept,
    output logic [C_PARAM_W-1:0]  job_parameters,
    input  logic                  job_fetch_request,
    output logic                  job_fetch_ack,
    input  logic                  job_fetch_complete,
    input  logic                  job_complete,
    output logic                  job_complete_ack,
    input  logic                  fetch_ready,
    output logic                  fetch_start,
    input  logic                  result_valid,
    output logic                  result_accept,
    input  logic [C_RESULT_W-1:0] result_data,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [C_RESULT_W-1:0] res_data,
    output logic                  res_last,
    input  logic                  clr_err,
    output logic                  busy,
    output logic                  job_done,
    output logic                  err_timeout,
    output logic                  err_count,
    output logic [C_CNT_W-1:0]    result_cnt
);

    state_t               state_q, state_d;
    logic [C_PARAM_W-1:0] params_q, params_d;
    logic [C_CNT_W-1:0]   exp_q, exp_d;
    logic [C_CNT_W-1:0]   cnt_q, cnt_d;
    logic                 job_start_q, job_start_d;
    logic                 err_timeout_q, err_timeout_d;
    logic                 err_count_q, err_count_d;

    logic                 fwd;
    logic                 xfer;
    logic                 desc_xfer;
    logic                 fetch_go;
    logic                 complete_go;
    logic [C_CNT_W-1:0]   cnt_inc;
    logic                 wd_enable;
    logic                 wd_reload;
    logic                 wd_expired;

    // Results only flow while the quad owns its data (FETCHING or RUN).
    assign fwd         = (state_q == FETCHING) || (state_q == RUN);
    assign xfer        = fwd && result_valid && res_ready;
    assign desc_xfer   = (state_q == IDLE) && desc_valid;
    assign fetch_go    = (state_q == WAIT_FETCH) && job_fetch_request && fetch_ready;
    assign complete_go = (state_q == RUN) && job_complete;
    assign cnt_inc     = (&cnt_q) ? cnt_q : (cnt_q + C_CNT_W'(1));

    // Protocol progress; a stalled phase falls into ERROR only if nothing else moved this cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:       if (desc_valid)         state_d = START;
            START:      if (job_accept)         state_d = WAIT_FETCH;
            WAIT_FETCH: if (fetch_go)           state_d = FETCHING;
            FETCHING:   if (job_fetch_complete) state_d = RUN;
            RUN:        if (job_complete)       state_d = IDLE;
            ERROR:      if (clr_err)            state_d = IDLE;
            default:                            state_d = IDLE;
        endcase
        if (wd_expired && (state_d == state_q) && !xfer) begin
            state_d = ERROR;
        end
    end

    // Descriptor latch, beat counter and sticky error flags.
    always_comb begin
        params_d      = params_q;
        exp_d         = exp_q;
        cnt_d         = cnt_q;
        err_timeout_d = err_timeout_q;
        err_count_d   = err_count_q;
        job_start_d   = (state_d == START);
        if (desc_xfer) begin
            params_d = desc_params;
            exp_d    = desc_num_results;
            cnt_d    = '0;
        end else if (xfer) begin
            cnt_d = cnt_inc;
        end
        if (clr_err) begin
            err_timeout_d = 1'b0;
            err_count_d   = 1'b0;
        end
        // cnt_d already includes a beat landing on the completion cycle.
        if (complete_go && (exp_q != '0) && (cnt_d != exp_q)) begin
            err_count_d = 1'b1;
        end
        if ((state_d == ERROR) && (state_q != ERROR)) begin
            err_timeout_d = 1'b1;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk_if or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            params_q      <= '0;
            exp_q         <= '0;
            cnt_q         <= '0;
            job_start_q   <= 1'b0;
            err_timeout_q <= 1'b0;
            err_count_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            params_q      <= params_d;
            exp_q         <= exp_d;
            cnt_q         <= cnt_d;
            job_start_q   <= job_start_d;
            err_timeout_q <= err_timeout_d;
            err_count_q   <= err_count_d;
        end
    end

    // Watchdog runs in every waiting phase; any phase change or result beat counts as progress.
    assign wd_enable = (state_q != IDLE) && (state_q != ERROR);
    assign wd_reload = (state_d != state_q) || xfer;

    cnl_watchdog_timer #(
        .C_TIMEOUT_CYCLES (C_TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk_if  (clk_if),
        .rst_n   (rst_n),
        .enable  (wd_enable),
        .reload  (wd_reload),
        .expired (wd_expired)
    );

    assign desc_ready       = (state_q == IDLE);
    assign busy             = (state_q != IDLE);
    assign job_start        = job_start_q;
    assign job_parameters   = params_q;
    assign job_fetch_ack    = fetch_go;
    assign fetch_start      = fetch_go;
    assign job_complete_ack = complete_go;
    assign job_done         = complete_go;
    assign res_valid        = fwd && result_valid;
    assign res_data         = fwd ? result_data : '0;
    assign result_accept    = fwd && res_ready;
    assign res_last         = res_valid && (exp_q != '0) && (cnt_q == exp_q - C_CNT_W'(1));
    assign err_timeout      = err_timeout_q;
    assign err_count        = err_count_q;
    assign result_cnt       = cnt_q;

endmodule

// File: tb/tb_cnl_job_sequencer.sv
module tb_cnl_job_sequencer;

    localparam int PW = 128;
    localparam int RW = 16;
    localparam int CW = 32;
    localparam int TO = 16;

    logic          clk_if;
    logic          rst_n;
    logic          desc_valid;
    logic          desc_ready;
    logic [PW-1:0] desc_params;
    logic [CW-1:0] desc_num_results;
    logic          job_start;
    logic          job_accept;
    logic [PW-1:0] job_parameters;
    logic          job_fetch_request;
    logic          job_fetch_ack;
    logic          job_fetch_complete;
    logic          job_complete;
    logic          job_complete_ack;
    logic          fetch_ready;
    logic          fetch_start;
    logic          result_valid;
    logic          result_accept;
    logic [RW-1:0] result_data;
    logic          res_valid;
    logic          res_ready;
    logic [RW-1:0] res_data;
    logic          res_last;
    logic          clr_err;
    logic          busy;
    logic          job_done;
    logic          err_timeout;
    logic          err_count;
    logic [CW-1:0] result_cnt;

    int vectors    = 0;
    int miscompares = 0;
    bit err_model  = 0;

    cnl_job_sequencer #(
        .C_PARAM_W        (PW),
        .C_RESULT_W       (RW),
        .C_CNT_W          (CW),
        .C_TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_if             (clk_if),
        .rst_n              (rst_n),
        .desc_valid         (desc_valid),
        .desc_ready         (desc_ready),
        .desc_params        (desc_params),
        .desc_num_results   (desc_num_results),
        .job_start          (job_start),
        .job_accept         (job_accept),
        .job_parameters     (job_parameters),
        .job_fetch_request  (job_fetch_request),
        .job_fetch_ack      (job_fetch_ack),
        .job_fetch_complete (job_fetch_complete),
        .job_complete       (job_complete),
        .job_complete_ack   (job_complete_ack),
        .fetch_ready        (fetch_ready),
        .fetch_start        (fetch_start),
        .result_valid       (result_valid),
        .result_accept      (result_accept),
        .result_data        (result_data),
        .res_valid          (res_valid),
        .res_ready          (res_ready),
        .res_data           (res_data),
        .res_last           (res_last),
        .clr_err            (clr_err),
        .busy               (busy),
        .job_done           (job_done),
        .err_timeout        (err_timeout),
        .err_count          (err_count),
        .result_cnt         (result_cnt)
    );

    initial begin
        clk_if = 1'b0;
        forever #5 clk_if = ~clk_if;
    end

    task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_if);
        #1;
    endtask

    task automatic clear_inputs();
        desc_valid = 0; desc_params = '0; desc_num_results = '0;
        job_accept = 0; job_fetch_request = 0; job_fetch_complete = 0;
        job_complete = 0; fetch_ready = 0; result_valid = 0;
        result_data = '0; res_ready = 0; clr_err = 0;
    endtask

    // One job through the whole protocol. Expected beats live in a queue; the
    // expected count/last/error follow directly from the descriptor and beat count.
    task automatic run_job(input int exp_n, input int nbeats, input int acc_dly,
                           input int frdy_dly, input int bp_mode, input bit coincide,
                           input int fc_at, input bit early);
        logic [PW-1:0] p;
        logic [RW-1:0] q[$];
        int  sent, cyc, idle;
        bit  v, r, cdrv, ack_exp;
        p = {$urandom(), $urandom(), $urandom(), $urandom()};
        for (int i = 0; i < nbeats; i++) q.push_back(RW'($urandom()));

        chk("idle_desc_ready", desc_ready, 1);
        chk("idle_busy", busy, 0);
        desc_valid = 1; desc_params = p; desc_num_results = CW'(exp_n);
        step();
        desc_valid = 0;
        chk("start_job_start", job_start, 1);
        chk("start_params", job_parameters, p);
        chk("start_cnt_clr", result_cnt, 0);
        chk("start_busy", busy, 1);
        for (int i = 0; i < acc_dly; i++) begin
            step();
            chk("start_hold", job_start, 1);
        end
        job_accept = 1;
        step();
        job_accept = 0;
        chk("accept_drop", job_start, 0);

        job_fetch_request = 1; fetch_ready = 0;
        for (int i = 0; i < frdy_dly; i++) begin
            #1;
            chk("fetch_wait_ack", job_fetch_ack, 0);
            chk("fetch_wait_start", fetch_start, 0);
            step();
        end
        fetch_ready = 1;
        #1;
        chk("fetch_ack", job_fetch_ack, 1);
        chk("fetch_start", fetch_start, 1);
        step();
        job_fetch_request = 0;

        sent = 0; cyc = 0; idle = 0;
        while (cyc < 400) begin
            case (bp_mode)
                0: begin v = (sent < nbeats) && ($urandom_range(0, 3) != 0); r = 1; end
                1: begin v = (sent < nbeats); r = (cyc % 2 == 0); end
                default: begin v = (sent < nbeats) && ($urandom_range(0, 3) != 0); r = $urandom_range(0, 1) == 1; end
            endcase
            if (idle >= 6 && sent < nbeats) begin v = 1; r = 1; end
            if (coincide && sent == nbeats - 1) begin v = 1; r = 1; end
            cdrv = early || ((cyc > fc_at) &&
                    (sent == nbeats || (coincide && sent == nbeats - 1)));
            ack_exp = cdrv && (cyc > fc_at);
            result_valid = v;
            result_data  = v ? q[sent] : RW'($urandom());
            res_ready    = r;
            job_fetch_complete = (cyc == fc_at);
            job_complete = cdrv;
            #1;
            chk("fwd_accept", result_accept, r);
            chk("fwd_valid", res_valid, v);
            if (v) begin
                chk("fwd_data", res_data, q[sent]);
                chk("fwd_last", res_last, (exp_n != 0) && (sent == exp_n - 1));
            end
            chk("cmpl_ack", job_complete_ack, ack_exp);
            chk("job_done", job_done, ack_exp);
            chk("no_refetch", job_fetch_ack, 0);
            if (v && r) begin sent++; idle = 0; end
            else idle++;
            step();
            cyc++;
            if (ack_exp) break;
        end
        chk("beats_sent", sent, nbeats);

        clear_inputs();
        #1;
        err_model = err_model | ((exp_n != 0) && (nbeats != exp_n));
        chk("post_busy", busy, 0);
        chk("post_desc_ready", desc_ready, 1);
        chk("post_cnt", result_cnt, nbeats);
        chk("post_err_count", err_count, err_model);
        chk("post_err_timeout", err_timeout, 0);
        chk("post_ack_low", job_complete_ack, 0);
    endtask

    initial begin
        int ne, nb;
        logic [PW-1:0] tp;
        clear_inputs();
        rst_n = 0;
        #1;
        chk("rst_desc_ready", desc_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_job_start", job_start, 0);
        chk("rst_params", job_parameters, 0);
        chk("rst_cnt", result_cnt, 0);
        chk("rst_errs", {err_timeout, err_count}, 0);
        step(); step();
        rst_n = 1;
        step();

        // Nominal, backpressure, mismatch and the sticky follow-up.
        run_job(4, 4, 2, 0, 0, 0, 0, 0);
        run_job(6, 6, 1, 0, 1, 0, 0, 0);
        run_job(5, 3, 0, 0, 0, 0, 0, 0);
        run_job(3, 3, 0, 0, 0, 0, 0, 0);

        // clr_err outside ERROR clears flags but leaves IDLE alone.
        clr_err = 1;
        step();
        clr_err = 0;
        err_model = 0;
        chk("clr_idle_err_count", err_count, 0);
        chk("clr_idle_desc_ready", desc_ready, 1);

        // Movers not ready for 10 cycles.
        run_job(2, 2, 0, 10, 0, 0, 0, 0);
        // Last beat on the completion cycle: counted before the compare.
        run_job(4, 4, 0, 0, 2, 1, 0, 0);
        run_job(3, 2, 0, 0, 2, 1, 0, 0);
        // Completion raised during FETCHING, serviced once RUN is reached.
        run_job(0, 0, 0, 0, 0, 0, 3, 1);

        for (int j = 0; j < 8; j++) begin
            nb = $urandom_range(0, 8);
            case ($urandom_range(0, 3))
                0: ne = 0;
                1: ne = $urandom_range(1, 8);
                default: ne = nb;
            endcase
            run_job(ne, nb, $urandom_range(0, 5), $urandom_range(0, 10),
                    $urandom_range(0, 2), (nb >= 2) && ($urandom_range(0, 1) == 1), 0, 0);
        end

        // Watchdog: quad never accepts; a second descriptor must be ignored meanwhile.
        tp = {$urandom(), $urandom(), $urandom(), $urandom()};
        desc_valid = 1; desc_params = tp; desc_num_results = 1;
        step();
        desc_valid = 0;
        chk("to_job_start", job_start, 1);
        for (int i = 1; i <= TO; i++) begin
            desc_valid = 1; desc_params = ~tp;
            #1;
            chk("busy_desc_ready", desc_ready, 0);
            step();
            desc_valid = 0;
            if (i < TO) begin
                chk("to_pending", err_timeout, 0);
                chk("to_start_hold", job_start, 1);
            end
        end
        chk("to_err", err_timeout, 1);
        chk("to_job_start_low", job_start, 0);
        chk("to_busy", busy, 1);
        chk("to_desc_ready", desc_ready, 0);
        chk("to_params_kept", job_parameters, tp);
        step();
        chk("err_state_hold", err_timeout, 1);
        clr_err = 1;
        step();
        clr_err = 0;
        chk("clr_desc_ready", desc_ready, 1);
        chk("clr_busy", busy, 0);
        chk("clr_err_timeout", err_timeout, 0);

        // Reset in RUN with a beat on the wire.
        desc_valid = 1; desc_params = tp; desc_num_results = 4;
        step();
        desc_valid = 0; job_accept = 1;
        step();
        job_accept = 0; job_fetch_request = 1; fetch_ready = 1;
        step();
        job_fetch_request = 0; job_fetch_complete = 1;
        step();
        job_fetch_complete = 0;
        result_valid = 1; result_data = RW'($urandom()); res_ready = 1;
        #1;
        chk("pre_rst_res_valid", res_valid, 1);
        rst_n = 0;
        #1;
        chk("mid_rst_desc_ready", desc_ready, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_res_valid", res_valid, 0);
        chk("mid_rst_accept", result_accept, 0);
        chk("mid_rst_data", res_data, 0);
        chk("mid_rst_cnt", result_cnt, 0);
        chk("mid_rst_params", job_parameters, 0);
        job_complete = 1;
        #1;
        chk("mid_rst_no_ack", job_complete_ack, 0);
        chk("mid_rst_no_done", job_done, 0);
        clear_inputs();
        #1;
        rst_n = 1;
        step();
        chk("post_rst_desc_ready", desc_ready, 1);
        chk("post_rst_job_start", job_start, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cnl_job_sequencer.md
Name: cnl_job_sequencer

Overview:
Synthesizable host-side initiator for the quad job protocol: the hardware counterpart of the bench job driver. Takes a job descriptor from upstream control, drives the quad's job_start/job_fetch_ack/job_complete_ack handshakes and triggers the external config/weight/pixel movers. Forwards quad results downstream with a beat count, and flags count mismatches and protocol timeouts. Sits between the layer scheduler and one cnn_layer_accel_quad, in the clk_if domain.

Parameters:
C_PARAM_W, 128, job_parameters / descriptor width
C_RESULT_W, 16, result beat width
C_CNT_W, 32, result counter width
C_TIMEOUT_CYCLES, 1000000, idle cycles in any non-IDLE state before timeout

Ports:
clk_if  in  1  interface clock
rst_n  in  1  reset, asynchronous, active-low
desc_valid  in  1  descriptor offered
desc_ready  out  1  sequencer can take descriptor
desc_params  in  C_PARAM_W  job parameters for quad
desc_num_results  in  C_CNT_W  expected result beats, 0 = unchecked
job_start  out  1  to quad
job_accept  in  1  from quad
job_parameters  out  C_PARAM_W  to quad, held from START to IDLE
job_fetch_request  in  1  quad requests data, level held until ack
job_fetch_ack  out  1  one-cycle pulse
job_fetch_complete  in  1  quad has all data
job_complete  in  1  quad finished, level held until ack
job_complete_ack  out  1  one-cycle pulse
fetch_ready  in  1  external movers idle and armed
fetch_start  out  1  one-cycle pulse to movers, coincident with job_fetch_ack
result_valid  in  1  from quad
result_accept  out  1  to quad
result_data  in  C_RESULT_W  from quad
res_valid  out  1  downstream result
res_ready  in  1  downstream ready
res_data  out  C_RESULT_W  downstream data
res_last  out  1  marks beat number desc_num_results
clr_err  in  1  clears sticky errors, leaves ERROR
busy  out  1  state != IDLE
job_done  out  1  one-cycle pulse on completion
err_timeout  out  1  sticky
err_count  out  1  sticky, beats != expected at completion
result_cnt  out  C_CNT_W  beats transferred this job

Behaviour:
- Reset: all outputs 0, except desc_ready=1. State IDLE; counters and latched params are 0. Reset mid-job aborts immediately with no acks issued.
- IDLE: desc_ready=1. A desc_valid&desc_ready transfer latches params and the expected count, clears result_cnt, then moves to START.
- START: job_start=1 (registered). On job_accept, job_start drops the next cycle and the FSM moves to WAIT_FETCH.
- WAIT_FETCH: on job_fetch_request&fetch_ready, assert job_fetch_ack and fetch_start for exactly one cycle, then move to FETCHING. If fetch_ready=0, stay in WAIT_FETCH.
- FETCHING: on job_fetch_complete, move to RUN. If job_complete arrives first, it is held and serviced after RUN is entered.
- RUN: on job_complete, pulse job_complete_ack for one cycle and move to IDLE, with job_done pulsing on the same cycle.
- Result forwarding in FETCHING and RUN is combinational passthrough:
  - res_valid = result_valid; res_data = result_data; result_accept = res_ready.
  - In all other states res_valid=0 and result_accept=0.
- A beat transfers when result_valid&res_ready; each transfer increments result_cnt (saturating).
- res_last=1 when res_valid and result_cnt==desc_num_results-1, with desc_num_results≠0.
- Count check on the job_complete cycle:
  - A beat transferring on that same cycle is counted before the compare.
  - If desc_num_results≠0 and the final count ≠ expected, err_count is set.
- Watchdog, non-IDLE states only:
  - Counter reloads on every state change or result transfer.
  - On reaching C_TIMEOUT_CYCLES, set err_timeout and enter ERROR.
- ERROR: all handshake outputs 0, desc_ready=0, busy=1. clr_err returns the FSM to IDLE and clears both error flags.
- clr_err in any other state clears the flags only.
- Descriptor arriving while busy: desc_ready=0, no effect.

Decomposition:
- Package cnl_job_seq_pkg holds:
  - state enum {IDLE, START, WAIT_FETCH, FETCHING, RUN, ERROR}
  - width constants
  - default timeout
- Sub-module cnl_watchdog_timer holds the reloadable down-counter with a reload input and an expired output; it is instantiated once.

Test Plan:
- Nominal, desc_num_results=4, quad accepts 2 cycles after start, 4 results with res_ready=1 → single job_fetch_ack/fetch_start pulse, res_last on 4th beat, job_complete_ack one cycle, job_done=1, err_count=0, result_cnt=4.
- Backpressure, res_ready toggling 1/0 over 6 beats → result_accept mirrors res_ready, no beat lost or duplicated, result_cnt=6.
- Mismatch, expected 5, 3 beats delivered before job_complete → err_count=1 sticky; the next descriptor is still accepted.
- fetch_ready held 0 for 10 cycles during job_fetch_request → no ack for those 10 cycles; ack on the first cycle fetch_ready=1.
- Timeout with C_TIMEOUT_CYCLES=16, job_accept never asserted → err_timeout after 16 cycles in START, state ERROR, job_start=0; clr_err returns to IDLE with desc_ready=1.
- Async reset asserted in RUN mid-beat → all outputs 0 and desc_ready=1 immediately; no job_complete_ack issued.
